// File: rtl/hex_frame_pkg.sv
// Shared types and constants for the hex frame receive path.
// Optional checksum digit is enabled by defining HEX_FRAME_CHKSUM_EN.
package hex_frame_pkg;

  // Sequencer states. CHK is only entered when the checksum feature is built.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_END = 2'd2,
    CHK      = 2'd3
  } state_t;

  // ASCII range limits for hex characters.
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;

  // Default frame delimiters: '#' starts a frame, CR ends it.
  localparam logic [7:0] DEF_HEAD = 8'h23;
  localparam logic [7:0] DEF_TAIL = 8'h0D;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII-to-nibble decoder. Accepts 0-9, A-F and a-f;
// anything else reports is_hex=0 with a zero nibble.
module hex_char_decode
  import hex_frame_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Classify the character and convert it to its 4-bit value.
  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (ch >= CH_0 && ch <= CH_9) begin
      is_hex = 1'b1;
      nibble = 4'(ch - CH_0);
    end else if (ch >= CH_A_UP && ch <= CH_F_UP) begin
      is_hex = 1'b1;
      nibble = 4'(ch - CH_A_UP) + 4'd10;
    end else if (ch >= CH_A_LO && ch <= CH_F_LO) begin
      is_hex = 1'b1;
      nibble = 4'(ch - CH_A_LO) + 4'd10;
    end
  end

endmodule

// File: rtl/hex_frame_ctrl.sv
// UART receive sequencer: recognises HEAD, DIGITS hex characters, TAIL and
// publishes the packed payload (first digit in the MSBs) on dout with a
// one-cycle dout_vld. Malformed frames and inter-byte timeouts pulse err.
// Define HEX_FRAME_CHKSUM_EN to require an extra hex digit after the data,
// equal to the XOR of all data nibbles, before TAIL.
module hex_frame_ctrl
  import hex_frame_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter logic [7:0]  HEAD        = DEF_HEAD,
  parameter logic [7:0]  TAIL        = DEF_TAIL,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          din,
  input  logic                din_vld,
  output logic [4*DIGITS-1:0] dout,
  output logic                dout_vld,
  output logic                err
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg;
  logic [TW-1:0] timer;
  logic [3:0]    nibble;
  logic          is_hex;
`ifdef HEX_FRAME_CHKSUM_EN
  logic [3:0]    csum;
`endif

  hex_char_decode u_decode (
    .ch     (din),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  // Frame sequencer with registered outputs and inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      timer    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      err      <= 1'b0;
`ifdef HEX_FRAME_CHKSUM_EN
      csum     <= '0;
`endif
    end else begin
      dout_vld <= 1'b0;
      err      <= 1'b0;

      // Timer only counts idle clocks inside a frame.
      if (state == IDLE || din_vld) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      // A byte arriving on the timeout clock takes priority over the timeout.
      if (din_vld) begin
        case (state)
          IDLE: begin
            if (din == HEAD) begin
              cnt   <= '0;
              shreg <= '0;
`ifdef HEX_FRAME_CHKSUM_EN
              csum  <= '0;
`endif
              state <= COLLECT;
            end
          end

          COLLECT: begin
            if (is_hex) begin
              shreg <= (shreg << 4) | DW'(nibble);
              cnt   <= cnt + 1'b1;
`ifdef HEX_FRAME_CHKSUM_EN
              csum  <= csum ^ nibble;
              if (cnt == CNT_LAST) state <= CHK;
`else
              if (cnt == CNT_LAST) state <= WAIT_END;
`endif
            end else if (din == HEAD) begin
              err   <= 1'b1;
              cnt   <= '0;
              shreg <= '0;
`ifdef HEX_FRAME_CHKSUM_EN
              csum  <= '0;
`endif
              state <= COLLECT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end

`ifdef HEX_FRAME_CHKSUM_EN
          CHK: begin
            if (is_hex && nibble == csum) begin
              state <= WAIT_END;
            end else if (din == HEAD) begin
              err   <= 1'b1;
              cnt   <= '0;
              shreg <= '0;
              csum  <= '0;
              state <= COLLECT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
`endif

          WAIT_END: begin
            if (din == TAIL) begin
              dout     <= shreg;
              dout_vld <= 1'b1;
              state    <= IDLE;
            end else if (din == HEAD) begin
              err   <= 1'b1;
              cnt   <= '0;
              shreg <= '0;
`ifdef HEX_FRAME_CHKSUM_EN
              csum  <= '0;
`endif
              state <= COLLECT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timer == TMO_LAST) begin
        err   <= 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hex_frame_ctrl.sv
// Directed bench for hex_frame_ctrl (DIGITS=4, TIMEOUT_CYC=16).
// Frames carry a checksum digit when HEX_FRAME_CHKSUM_EN is defined.
module tb_hex_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        din_vld = 1'b0;
  logic [15:0] dout;
  logic        dout_vld;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  hex_frame_ctrl #(
    .DIGITS      (4),
    .HEAD        (8'h23),
    .TAIL        (8'h0D),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the next posedge and the
  // task returns on the following negedge with that edge's outputs visible.
  task automatic send_byte(input logic [7:0] b);
    din     = b;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    din     = '0;
  endtask

  // Bytes expected to produce neither err nor dout_vld.
  task automatic send_quiet(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_vld"}, 32'(dout_vld), 32'd0);
    end
  endtask

  // Body sent quietly, then TAIL must publish exp for exactly one cycle.
  task automatic frame_ok(input string body, input logic [15:0] exp, input string tag);
    send_quiet(body, tag);
    send_byte(8'h0D);
    chk({tag, "_vld1"}, 32'(dout_vld), 32'd1);
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_noerr"}, 32'(err), 32'd0);
    @(negedge clk);
    chk({tag, "_vld0"}, 32'(dout_vld), 32'd0);
  endtask

  function automatic string ck(input string c);
`ifdef HEX_FRAME_CHKSUM_EN
    return c;
`else
    return "";
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    // Reset state
    #12;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with mixed case
    s = {"#1A2f", ck("6")};
    frame_ok(s, 16'h1A2F, "f1a2f");

    // Non-hex digit aborts; dout must hold
    send_quiet("#12", "bad_pre");
    send_byte("G");
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_vld", 32'(dout_vld), 32'd0);
    chk("bad_hold", 32'(dout), 32'h1A2F);
    @(negedge clk);
    chk("bad_err_pulse", 32'(err), 32'd0);
    send_quiet("4\r", "bad_tail");
    chk("bad_hold2", 32'(dout), 32'h1A2F);
    s = {"#0000", ck("0")};
    frame_ok(s, 16'h0000, "f0000");

    // HEAD mid-frame restarts collection
    send_quiet("#12", "rs_pre");
    send_byte("#");
    chk("rs_err", 32'(err), 32'd1);
    s = {"BEEF", ck("4")};
    frame_ok(s, 16'hBEEF, "fbeef");

    // Digit boundaries 0, 9, a, f
    s = {"#09af", ck("C")};
    frame_ok(s, 16'h09AF, "f09af");

    // Timeout after 16 idle clocks
    send_quiet("#123", "tmo_pre");
    repeat (15) @(negedge clk);
    chk("tmo_early", 32'(err), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_vld", 32'(dout_vld), 32'd0);
    @(negedge clk);
    chk("tmo_pulse", 32'(err), 32'd0);
    send_quiet("5\r", "tmo_stray");
    chk("tmo_hold", 32'(dout), 32'h09AF);

    // Byte arriving on the timeout clock wins
    send_quiet("#1", "win_pre");
    repeat (15) @(negedge clk);
    send_byte("2");
    chk("win_err", 32'(err), 32'd0);
    s = {"34", ck("4")};
    frame_ok(s, 16'h1234, "fwin");

    // Reset mid-frame clears dout and discards the partial frame
    send_quiet("#AB", "mid_pre");
    rst_n = 1'b0;
    #1;
    chk("mid_dout", 32'(dout), 32'd0);
    chk("mid_vld", 32'(dout_vld), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = {"#CDEF", ck("0")};
    frame_ok(s, 16'hCDEF, "fcdef");

`ifdef HEX_FRAME_CHKSUM_EN
    // Checksum mismatch then match
    send_quiet("#1234", "cs_pre");
    send_byte("5");
    chk("cs_err", 32'(err), 32'd1);
    send_quiet("\r", "cs_tail");
    chk("cs_hold", 32'(dout), 32'hCDEF);
    frame_ok("#12344", 16'h1234, "fcs");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
